// File: rtl/fe_inverter_if.sv
// ---------------------------------------------------------------------------
// fe_inverter_if
// Request/response bundle of the GF(2^255-19) inverter.
//   start  : request, sampled by the inverter only while ready=1
//   a      : 255-bit operand (any value below 2^255)
//   ready  : inverter can accept start
//   done   : one-cycle pulse, result/err updated
//   result : a^(p-2) mod p, fully reduced, held until the next done
//   err    : zero-operand flag, valid with done
// master : the requester (drives start/a)
// slave  : the inverter
// ---------------------------------------------------------------------------
interface fe_inverter_if;
  logic         start;
  logic [254:0] a;
  logic         ready;
  logic         done;
  logic [254:0] result;
  logic         err;

  modport master (
    output start,
    output a,
    input  ready,
    input  done,
    input  result,
    input  err
  );

  modport slave (
    input  start,
    input  a,
    output ready,
    output done,
    output result,
    output err
  );
endinterface

// File: rtl/fe_inverter.sv
// ---------------------------------------------------------------------------
// fe_inverter
// Sequential inverter for GF(p), p = 2^255 - 19. Computes a^(p-2) mod p by
// left-to-right square-and-multiply over the hard-wired exponent p-2, sharing
// a single pipelined Karatsuba field multiplier (kom, 3-edge latency) for all
// 254 squarings and 252 multiplies. One inversion takes 506*4 = 2024 cycles.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : fe_inverter_if.slave (start, a, ready, done, result, err)
//
// Optional feature (macro FE_INV_ZERO_DETECT_EN):
//   defined   : a zero operand (after reduction) finishes one edge after the
//               accept edge with result=0 and err=1
//   undefined : err is tied to 0, zero runs the full schedule (0^(p-2) = 0)
//
// Also contains module kom: pipelined GF(p) multiplier, 256-bit zero-extended
// operands, 255-bit fully reduced product, result valid 3 edges after the
// operands are applied.
// ---------------------------------------------------------------------------

module kom (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] i_a,
  input  logic [255:0] i_b,
  output logic [254:0] o_p
);
  localparam logic [255:0] P256 = {1'b0, {250{1'b1}}, 5'b01101};

  // Stage 1: one-level Karatsuba partial products on 128-bit halves.
  logic [127:0] w_a0, w_a1, w_b0, w_b1;
  logic [128:0] w_sa, w_sb;
  logic [255:0] w_z0, w_z2;
  logic [257:0] w_zm;

  assign w_a0 = i_a[127:0];
  assign w_a1 = i_a[255:128];
  assign w_b0 = i_b[127:0];
  assign w_b1 = i_b[255:128];
  assign w_sa = {1'b0, w_a0} + {1'b0, w_a1};
  assign w_sb = {1'b0, w_b0} + {1'b0, w_b1};
  assign w_z0 = {128'b0, w_a0} * {128'b0, w_b0};
  assign w_z2 = {128'b0, w_a1} * {128'b0, w_b1};
  assign w_zm = {129'b0, w_sa} * {129'b0, w_sb};

  logic [255:0] r_z0, r_z2;
  logic [257:0] r_zm;

  // Stage 2: recombine, then fold bits above 2^255 using 2^255 = 19 (mod p).
  logic [257:0] w_z1;
  logic [511:0] w_full;
  logic [254:0] w_lo, w_hi;
  logic [259:0] w_t1;

  assign w_z1   = r_zm - {2'b0, r_z0} - {2'b0, r_z2};
  assign w_full = {r_z2, 256'b0} + ({254'b0, w_z1} << 128) + {256'b0, r_z0};
  assign w_lo   = 255'(w_full);
  assign w_hi   = 255'(w_full >> 255);
  assign w_t1   = {5'b0, w_lo} + ({5'b0, w_hi} * 260'd19);

  logic [259:0] r_t1;

  // Stage 3: second fold leaves a value below p + 399, so one conditional
  // subtract of p gives the fully reduced product.
  logic [255:0] w_t2, w_t2_sub;
  logic [254:0] w_red;

  assign w_t2     = {1'b0, r_t1[254:0]} + ({251'b0, r_t1[259:255]} * 256'd19);
  assign w_t2_sub = w_t2 - P256;
  assign w_red    = (w_t2 >= P256) ? 255'(w_t2_sub) : 255'(w_t2);

  logic [254:0] r_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z0 <= '0;
      r_z2 <= '0;
      r_zm <= '0;
      r_t1 <= '0;
      r_p  <= '0;
    end else begin
      r_z0 <= w_z0;
      r_z2 <= w_z2;
      r_zm <= w_zm;
      r_t1 <= w_t1;
      r_p  <= w_red;
    end
  end

  assign o_p = r_p;
endmodule

module fe_inverter (
  input  logic             clk,
  input  logic             rst,
  fe_inverter_if.slave     bus
);
  localparam int unsigned  MUL_LAT = 3;
  localparam int unsigned  CNT_W   = $clog2(MUL_LAT + 1);
  localparam logic [254:0] P       = {{250{1'b1}}, 5'b01101};
  // Exponent p-2: bits 254..5 set, low bits 01011.
  localparam logic [254:0] P_M2    = {{250{1'b1}}, 5'b01011};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQR,
    S_MUL,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_ready;
  logic               r_done;
  logic [254:0]       r_result;
  logic [7:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [254:0]       r_areg;
  logic [254:0]       r_x;
`ifdef FE_INV_ZERO_DETECT_EN
  logic               r_err;
`endif

  // Inputs below 2^255 are below 2p, so one conditional subtract reduces.
  logic [254:0] w_a_red;
  logic [254:0] w_op_b;
  logic [254:0] w_prod;
  logic         w_cnt_last;

  assign w_a_red    = (bus.a >= P) ? (bus.a - P) : bus.a;
  assign w_op_b     = (r_state == S_MUL) ? r_areg : r_x;
  assign w_cnt_last = (r_cnt == CNT_W'(MUL_LAT));

  kom u_kom (
    .clk (clk),
    .rst (rst),
    .i_a ({1'b0, r_x}),
    .i_b ({1'b0, w_op_b}),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_result <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_areg   <= '0;
      r_x      <= '0;
`ifdef FE_INV_ZERO_DETECT_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            // Top exponent bit is 1: the initial square of 1 is skipped by
            // starting from x = a at index 253.
            r_areg  <= w_a_red;
            r_x     <= w_a_red;
            r_idx   <= 8'd253;
            r_cnt   <= '0;
            r_state <= S_SQR;
            r_ready <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end

        S_SQR: begin
`ifdef FE_INV_ZERO_DETECT_EN
          if (r_areg == '0) begin
            r_state  <= S_DONE;
            r_ready  <= 1'b1;
            r_done   <= 1'b1;
            r_result <= '0;
            r_err    <= 1'b1;
          end else
`endif
          if (w_cnt_last) begin
            r_cnt <= '0;
            r_x   <= w_prod;
            if (P_M2[r_idx]) begin
              r_state <= S_MUL;
            end else if (r_idx == 8'd0) begin
              r_state  <= S_DONE;
              r_ready  <= 1'b1;
              r_done   <= 1'b1;
              r_result <= w_prod;
`ifdef FE_INV_ZERO_DETECT_EN
              r_err    <= 1'b0;
`endif
            end else begin
              r_idx <= r_idx - 8'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_MUL: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            r_x   <= w_prod;
            if (r_idx == 8'd0) begin
              r_state  <= S_DONE;
              r_ready  <= 1'b1;
              r_done   <= 1'b1;
              r_result <= w_prod;
`ifdef FE_INV_ZERO_DETECT_EN
              r_err    <= 1'b0;
`endif
            end else begin
              r_idx   <= r_idx - 8'd1;
              r_state <= S_SQR;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready  = r_ready;
  assign bus.done   = r_done;
  assign bus.result = r_result;
`ifdef FE_INV_ZERO_DETECT_EN
  assign bus.err    = r_err;
`else
  assign bus.err    = 1'b0;
`endif
endmodule
